// File: rtl/ghr_predictor_pkg.sv
// Shared branch-predictor definitions: 2-bit counter encoding and default table geometry.
// Imported by the gshare predictor, the local-history predictor and the chooser.
package ghr_predictor_pkg;

    localparam int GHR_BIT_DEF     = 8;
    localparam int PHT_IDX_BIT_DEF = 8;

    typedef logic [1:0] bp_cnt_t;

    localparam bp_cnt_t BP_SNT = 2'b00;
    localparam bp_cnt_t BP_WNT = 2'b01;
    localparam bp_cnt_t BP_WT  = 2'b10;
    localparam bp_cnt_t BP_ST  = 2'b11;

    localparam bp_cnt_t BP_RST = BP_WNT;

endpackage

// File: rtl/ghr_predictor_sat_cnt2.sv
// Next-state function of a 2-bit saturating counter.
// Shared by the PHT, BHT and chooser tables.
module sat_cnt2
    import ghr_predictor_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       inc,
    output logic [1:0] cnt_next
);

    always_comb begin
        cnt_next = cnt;
        if (inc) begin
            if (cnt != BP_ST) cnt_next = cnt + 2'd1;
        end else begin
            if (cnt != BP_SNT) cnt_next = cnt - 2'd1;
        end
    end

endmodule

// File: rtl/ghr_predictor.sv
// gshare direction predictor: speculative/architectural global history and a PHT of
// 2-bit counters indexed by pc XOR history, read asynchronously at IF1 and EX.
module ghr_predictor
    import ghr_predictor_pkg::*;
#(
    parameter int GHR_BIT     = GHR_BIT_DEF,
    parameter int PHT_IDX_BIT = PHT_IDX_BIT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        if1_pc,
    input  logic               if1_br_valid,
    input  logic               if1_stall,
    output logic               if1_answ_ghr,
    output logic [GHR_BIT-1:0] if1_ghr_snap,
    input  logic               ex_br_valid,
    input  logic [31:0]        ex_pc,
    input  logic [GHR_BIT-1:0] ex_ghr_snap,
    input  logic               branched,
    input  logic               ex_flush,
    output logic               ex_answ_ghr
);

    localparam int PHT_DEPTH = 1 << PHT_IDX_BIT;

    logic [GHR_BIT-1:0]     spec_ghr;
    logic [GHR_BIT-1:0]     arch_ghr;
    logic [GHR_BIT-1:0]     arch_ghr_next;
    bp_cnt_t                pht [PHT_DEPTH];
    logic [PHT_IDX_BIT-1:0] if1_idx;
    logic [PHT_IDX_BIT-1:0] ex_idx;
    bp_cnt_t                ex_cnt;
    bp_cnt_t                ex_cnt_next;
    logic                   pc_bits_unused;

    // History is zero-extended to the index width; XOR wraps naturally.
    assign if1_idx = if1_pc[PHT_IDX_BIT+1:2] ^ PHT_IDX_BIT'(spec_ghr);
    assign ex_idx  = ex_pc[PHT_IDX_BIT+1:2] ^ PHT_IDX_BIT'(ex_ghr_snap);

    assign pc_bits_unused = ^{if1_pc[31:PHT_IDX_BIT+2], if1_pc[1:0],
                              ex_pc[31:PHT_IDX_BIT+2], ex_pc[1:0]};

    assign if1_ghr_snap = spec_ghr;
    assign if1_answ_ghr = pht[if1_idx][1];

    assign ex_cnt      = pht[ex_idx];
    assign ex_answ_ghr = ex_br_valid & ex_cnt[1];

    assign arch_ghr_next = ex_br_valid ? {arch_ghr[GHR_BIT-2:0], branched} : arch_ghr;

    sat_cnt2 u_sat_cnt2 (
        .cnt      (ex_cnt),
        .inc      (branched),
        .cnt_next (ex_cnt_next)
    );

    // Flush repair takes priority over any same-cycle speculative shift.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            spec_ghr <= '0;
            arch_ghr <= '0;
        end else begin
            arch_ghr <= arch_ghr_next;
            if (ex_flush)
                spec_ghr <= arch_ghr_next;
            else if (if1_br_valid && !if1_stall)
                spec_ghr <= {spec_ghr[GHR_BIT-2:0], if1_answ_ghr};
        end
    end

    // Single write port from EX; reads above see the pre-write value this cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < PHT_DEPTH; i++)
                pht[i] <= BP_RST;
        end else if (ex_br_valid) begin
            pht[ex_idx] <= ex_cnt_next;
        end
    end

endmodule

// File: tb/tb_ghr_predictor.sv
// Scoreboard bench for ghr_predictor: a reference model predicts every cycle's outputs,
// which are queued when stimulus is applied and compared at the following negedge.
module tb_ghr_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if1_pc;
    logic        if1_br_valid;
    logic        if1_stall;
    logic        if1_answ_ghr;
    logic [7:0]  if1_ghr_snap;
    logic        ex_br_valid;
    logic [31:0] ex_pc;
    logic [7:0]  ex_ghr_snap;
    logic        branched;
    logic        ex_flush;
    logic        ex_answ_ghr;

    always #5 clk = ~clk;

    ghr_predictor #(.GHR_BIT(8), .PHT_IDX_BIT(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if1_pc       (if1_pc),
        .if1_br_valid (if1_br_valid),
        .if1_stall    (if1_stall),
        .if1_answ_ghr (if1_answ_ghr),
        .if1_ghr_snap (if1_ghr_snap),
        .ex_br_valid  (ex_br_valid),
        .ex_pc        (ex_pc),
        .ex_ghr_snap  (ex_ghr_snap),
        .branched     (branched),
        .ex_flush     (ex_flush),
        .ex_answ_ghr  (ex_answ_ghr)
    );

    typedef struct packed {
        logic       if1_answ;
        logic [7:0] snap;
        logic       ex_answ;
    } exp_t;

    exp_t  sb [$];
    int    n_cmp = 0;
    int    n_mis = 0;
    string tag;

    // Reference model state
    int         m_pht [256];
    logic [7:0] m_spec;
    logic [7:0] m_arch;

    task automatic check_eq(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, obs, exp);
        end
    endtask

    function automatic int m_idx(input logic [31:0] pc, input logic [7:0] h);
        return ((pc >> 2) ^ {24'd0, h}) % 256;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 256; i++) m_pht[i] = 1;
        m_spec = 8'h00;
        m_arch = 8'h00;
    endtask

    // Drive one cycle, queue the model's expectation, compare at negedge, advance model at posedge.
    task automatic cyc(input logic rn, input logic [31:0] p1, input logic v1, input logic st,
                       input logic v2, input logic [31:0] p2, input logic [7:0] sn,
                       input logic br, input logic fl);
        exp_t e, got;
        int   ii, ei;
        logic pred;
        logic [7:0] an;
        rst_n = rn; if1_pc = p1; if1_br_valid = v1; if1_stall = st;
        ex_br_valid = v2; ex_pc = p2; ex_ghr_snap = sn; branched = br; ex_flush = fl;
        ii   = m_idx(p1, m_spec);
        ei   = m_idx(p2, sn);
        pred = (m_pht[ii] >= 2);
        e.if1_answ = pred;
        e.snap     = m_spec;
        e.ex_answ  = v2 && (m_pht[ei] >= 2);
        sb.push_back(e);
        @(negedge clk);
        got = sb.pop_front();
        check_eq({tag, ".if1_answ"}, {31'd0, if1_answ_ghr}, {31'd0, got.if1_answ});
        check_eq({tag, ".snap"},     {24'd0, if1_ghr_snap}, {24'd0, got.snap});
        check_eq({tag, ".ex_answ"},  {31'd0, ex_answ_ghr},  {31'd0, got.ex_answ});
        if (!rn) begin
            m_reset();
        end else begin
            an = v2 ? {m_arch[6:0], br} : m_arch;
            if (v2) begin
                if (br && m_pht[ei] < 3) m_pht[ei] = m_pht[ei] + 1;
                else if (!br && m_pht[ei] > 0) m_pht[ei] = m_pht[ei] - 1;
            end
            if (fl) m_spec = an;
            else if (v1 && !st) m_spec = {m_spec[6:0], pred};
            m_arch = an;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 32'h0, 0, 0, 0, 32'h0, 8'h0, 0, 0);
    endtask

    task automatic ex_train(input logic [31:0] pc, input logic [7:0] sn, input logic br);
        cyc(1, 32'h0, 0, 0, 1, pc, sn, br, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        m_reset();
    endtask

    logic [7:0] bits_a, bits_b;

    initial begin
        rst_n = 1'b0; if1_pc = '0; if1_br_valid = 0; if1_stall = 0;
        ex_br_valid = 0; ex_pc = '0; ex_ghr_snap = '0; branched = 0; ex_flush = 0;
        m_reset();
        @(posedge clk); @(posedge clk); #1;

        tag = "reset";
        cyc(0, 32'h1C000010, 1, 0, 1, 32'h1C000010, 8'h00, 1, 0);

        tag = "first_fetch";
        cyc(1, 32'h1C000000, 1, 0, 0, 32'h0, 8'h00, 0, 0);
        cyc(1, 32'h1C000000, 0, 0, 0, 32'h0, 8'h00, 0, 0);

        tag = "train_taken";
        ex_train(32'h1C000010, 8'h00, 1);
        ex_train(32'h1C000010, 8'h00, 1);
        tag = "read_trained";
        cyc(1, 32'h1C000010, 0, 0, 0, 32'h0, 8'h00, 0, 0);
        tag = "train_nt";
        ex_train(32'h1C000010, 8'h00, 0);
        tag = "read_after_nt";
        cyc(1, 32'h1C000010, 0, 0, 1, 32'h1C000010, 8'h00, 0, 0);

        tag = "sat_up";
        for (int i = 0; i < 3; i++) ex_train(32'h1C000020, 8'h00, 1);
        tag = "sat_down";
        for (int i = 0; i < 4; i++) ex_train(32'h1C000020, 8'h00, 0);
        tag = "sat_floor";
        ex_train(32'h1C000020, 8'h00, 0);
        cyc(1, 32'h1C000020, 0, 0, 1, 32'h1C000020, 8'h00, 1, 0);

        tag = "repair";
        do_reset();
        bits_a = 8'hA7;
        bits_b = 8'h05;
        for (int i = 7; i >= 0; i--) ex_train(32'h1C000100, 8'h11, bits_a[i]);
        cyc(1, 32'h0, 0, 0, 0, 32'h0, 8'h00, 0, 1);
        for (int i = 7; i >= 0; i--) ex_train(32'h1C000100, 8'h22, bits_b[i]);
        cyc(1, 32'h1C000040, 1, 0, 1, 32'h1C000200, 8'h33, 1, 1);
        tag = "repaired";
        cyc(1, 32'h1C000040, 0, 0, 0, 32'h0, 8'h00, 0, 0);
        check_eq("repair.snap_const", {24'd0, if1_ghr_snap}, 32'h0B);

        tag = "stall";
        for (int i = 0; i < 3; i++) cyc(1, 32'h1C000044, 1, 1, 0, 32'h0, 8'h00, 0, 0);
        tag = "unstall";
        cyc(1, 32'h1C000044, 1, 0, 0, 32'h0, 8'h00, 0, 0);
        cyc(1, 32'h1C000044, 1, 0, 0, 32'h0, 8'h00, 0, 0);

        tag = "collision";
        do_reset();
        cyc(1, 32'h1C000030, 0, 0, 1, 32'h1C000030, 8'h00, 1, 0);
        cyc(1, 32'h1C000030, 0, 0, 0, 32'h0, 8'h00, 0, 0);

        tag = "random";
        for (int n = 0; n < 400; n++) begin
            cyc(($urandom_range(0, 49) != 0),
                32'h1C000000 + ($urandom_range(0, 15) << 2), ($urandom_range(0, 2) != 0),
                ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 2) != 0), 32'h1C000000 + ($urandom_range(0, 15) << 2),
                8'($urandom_range(0, 255)) & 8'h0F, $urandom_range(0, 1) != 0,
                ($urandom_range(0, 9) == 0));
        end

        tag = "tail";
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
